sram_bus_arbiter: RTL and testbench

//  Shares one sram-like bus (address/data split handshake) between CPU fetch (F) and data (M) ports.

---
 rtl/sram_bus_arbiter_pkg.sv | 15 +
 rtl/sram_bus_arbiter_chk.sv | 21 ++
 rtl/sram_bus_arbiter_done_flag.sv | 22 ++
 rtl/sram_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data SRAM-bus arbiter.
// State encodings and the fixed transfer size live here so the checker and top agree.
package sram_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE   = 3'd0,
      ARB_I_ADDR = 3'd1,
      ARB_I_DATA = 3'd2,
      ARB_D_ADDR = 3'd3,
      ARB_D_DATA = 3'd4
   } arbState_e;

   localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/sram_bus_arbiter_chk.sv
// Bus-protocol checks for the arbiter: responses only in a data phase,
// and an unaccepted request keeps its address stable.
module sram_bus_arbiter_chk #(
   parameter int AW = 32
) (
   input logic          clk,
   input logic          rst,
   input logic          dataPhase,
   input logic          busReq,
   input logic          busAddrOk,
   input logic          busDataOk,
   input logic [AW-1:0] busAddr
);

   dataOkInPhase: assert property (@(posedge clk) disable iff (!rst)
      busDataOk |-> dataPhase);

   reqHeldUntilAccept: assert property (@(posedge clk) disable iff (!rst)
      (busReq && !busAddrOk) |=> (busReq && $stable(busAddr)));

endmodule

// File: rtl/sram_bus_arbiter_done_flag.sv
// Completion flag held while the pipeline is frozen, cleared once it advances.
// A new completion in the same cycle as an advance wins over the clear.
module sram_bus_arbiter_done_flag (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic clr,
   output logic flag
);

   // Set/clear flag register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag <= 1'b0;
      end else if (set) begin
         flag <= 1'b1;
      end else if (clr) begin
         flag <= 1'b0;
      end
   end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one split address/data SRAM-style bus between the fetch and memory ports,
// one transaction outstanding, data port first; returned words are held until the pipeline advances.
module sram_bus_arbiter
   import sram_bus_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_req,
   input  logic [AW-1:0]   inst_addr,
   output logic [DW-1:0]   inst_rdata,
   output logic            i_stall,
   input  logic            data_req,
   input  logic [DW/8-1:0] data_wen,
   input  logic [AW-1:0]   data_addr,
   input  logic [DW-1:0]   data_wdata,
   output logic [DW-1:0]   data_rdata,
   output logic            d_stall,
   input  logic            longest_stall,
   output logic            bus_req,
   output logic            bus_wr,
   output logic [1:0]      bus_size,
   output logic [DW/8-1:0] bus_wstrb,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   input  logic            bus_addr_ok,
   input  logic            bus_data_ok,
   input  logic [DW-1:0]   bus_rdata
);

   localparam logic [AW-1:0] KSEG_MASK = {3'b000, {(AW-3){1'b1}}};

   arbState_e stateR, stateNext_s;
   logic      iDone_s, dDone_s;
   logic      iPend_s, dPend_s;
   logic      issueI_s, issueD_s;
   logic      ownerReq_s, dataPhase_s, discard_s;
   logic      iSet_s, dSet_s;
   logic      abortR;

   // kseg0/kseg1 windows fold onto the low 512 MB; everything else passes through
   function automatic logic [AW-1:0] mapAddr(input logic [AW-1:0] a);
      mapAddr = (a[AW-1 -: 2] == 2'b10) ? (a & KSEG_MASK) : a;
   endfunction

   assign bus_size = SIZE_WORD;

   // Pending requests, stalls and completion qualifiers
   always_comb begin
      iPend_s     = inst_req & ~iDone_s;
      dPend_s     = data_req & ~dDone_s;
      i_stall     = iPend_s | (stateR == ARB_I_ADDR) | (stateR == ARB_I_DATA);
      d_stall     = dPend_s | (stateR == ARB_D_ADDR) | (stateR == ARB_D_DATA);
      dataPhase_s = (stateR == ARB_I_DATA) | (stateR == ARB_D_DATA);
      if ((stateR == ARB_I_ADDR) || (stateR == ARB_I_DATA)) begin
         ownerReq_s = inst_req;
      end else if ((stateR == ARB_D_ADDR) || (stateR == ARB_D_DATA)) begin
         ownerReq_s = data_req;
      end else begin
         ownerReq_s = 1'b1;
      end
      // a request dropped at any point during its transaction throws the response away
      discard_s = abortR | ~ownerReq_s;
      iSet_s    = bus_data_ok & (stateR == ARB_I_DATA) & ~discard_s;
      dSet_s    = bus_data_ok & (stateR == ARB_D_DATA) & ~discard_s;
   end

   // Next-state logic; data side wins in IDLE as the older instruction
   always_comb begin
      stateNext_s = stateR;
      issueI_s    = 1'b0;
      issueD_s    = 1'b0;
      case (stateR)
         ARB_IDLE: begin
            if (dPend_s) begin
               stateNext_s = ARB_D_ADDR;
               issueD_s    = 1'b1;
            end else if (iPend_s) begin
               stateNext_s = ARB_I_ADDR;
               issueI_s    = 1'b1;
            end else begin
               stateNext_s = ARB_IDLE;
            end
         end
         ARB_I_ADDR: stateNext_s = bus_addr_ok ? ARB_I_DATA : ARB_I_ADDR;
         ARB_I_DATA: stateNext_s = bus_data_ok ? ARB_IDLE : ARB_I_DATA;
         ARB_D_ADDR: stateNext_s = bus_addr_ok ? ARB_D_DATA : ARB_D_ADDR;
         ARB_D_DATA: stateNext_s = bus_data_ok ? ARB_IDLE : ARB_D_DATA;
         default:    stateNext_s = ARB_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateR <= ARB_IDLE;
      end else begin
         stateR <= stateNext_s;
      end
   end

   // Bus request fields, captured at issue and held until the slave accepts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_req   <= 1'b0;
         bus_wr    <= 1'b0;
         bus_wstrb <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
      end else if (issueD_s) begin
         bus_req   <= 1'b1;
         bus_wr    <= |data_wen;
         bus_wstrb <= data_wen;
         bus_addr  <= mapAddr(data_addr);
         bus_wdata <= data_wdata;
      end else if (issueI_s) begin
         bus_req   <= 1'b1;
         bus_wr    <= 1'b0;
         bus_wstrb <= '0;
         bus_addr  <= mapAddr(inst_addr);
         bus_wdata <= '0;
      end else if (bus_req && bus_addr_ok) begin
         bus_req   <= 1'b0;
      end
   end

   // Remembers a withdrawal that happened earlier in the current transaction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         abortR <= 1'b0;
      end else if (issueI_s || issueD_s) begin
         abortR <= 1'b0;
      end else if ((stateR != ARB_IDLE) && !ownerReq_s) begin
         abortR <= 1'b1;
      end
   end

   // Returned words; writes leave the load register untouched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_rdata <= '0;
         data_rdata <= '0;
      end else begin
         if (iSet_s) begin
            inst_rdata <= bus_rdata;
         end
         if (dSet_s && !bus_wr) begin
            data_rdata <= bus_rdata;
         end
      end
   end

   sram_bus_arbiter_done_flag uIDoneFlag (
      .clk  (clk),
      .rst  (rst),
      .set  (iSet_s),
      .clr  (~longest_stall),
      .flag (iDone_s)
   );

   sram_bus_arbiter_done_flag uDDoneFlag (
      .clk  (clk),
      .rst  (rst),
      .set  (dSet_s),
      .clr  (~longest_stall),
      .flag (dDone_s)
   );

   sram_bus_arbiter_chk #(.AW(AW)) uChk (
      .clk       (clk),
      .rst       (rst),
      .dataPhase (dataPhase_s),
      .busReq    (bus_req),
      .busAddrOk (bus_addr_ok),
      .busDataOk (bus_data_ok),
      .busAddr   (bus_addr)
   );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model that also plays the bus slave.
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = 32'd0;
   logic [31:0] inst_rdata;
   logic        i_stall;
   logic        data_req = 1'b0;
   logic [3:0]  data_wen = 4'd0;
   logic [31:0] data_addr = 32'd0;
   logic [31:0] data_wdata = 32'd0;
   logic [31:0] data_rdata;
   logic        d_stall;
   logic        longest_stall = 1'b0;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok = 1'b0;
   logic        bus_data_ok = 1'b0;
   logic [31:0] bus_rdata = 32'd0;

   int errors = 0;
   int checks = 0;

   // model: done flags, held words, and the one outstanding transaction
   logic        mIDone, mDDone, mBusy, mOwnerD, mAccepted, mAborted, mWr;
   logic [31:0] mInstRdata, mDataRdata, mAddr, mWdata;
   logic [3:0]  mStrb;
   int          reqAge, dataAge, aDly, dDly;

   bit          autoStall, randExtra, fixedDly, forceDataOk, useRdataFix;
   int          aDlyFix, dDlyFix;
   logic [31:0] rdataFix;

   logic        obsIStall, obsDStall, obsBusReq;
   logic [31:0] acceptAddr[$];
   logic        acceptWr[$];
   logic [3:0]  acceptStrb[$];

   always #5 clk = ~clk;

   sram_bus_arbiter #(.AW(32), .DW(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_rdata    (inst_rdata),
      .i_stall       (i_stall),
      .data_req      (data_req),
      .data_wen      (data_wen),
      .data_addr     (data_addr),
      .data_wdata    (data_wdata),
      .data_rdata    (data_rdata),
      .d_stall       (d_stall),
      .longest_stall (longest_stall),
      .bus_req       (bus_req),
      .bus_wr        (bus_wr),
      .bus_size      (bus_size),
      .bus_wstrb     (bus_wstrb),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_addr_ok   (bus_addr_ok),
      .bus_data_ok   (bus_data_ok),
      .bus_rdata     (bus_rdata)
   );

   function automatic logic [31:0] phys(input logic [31:0] va);
      if (va >= 32'h8000_0000 && va < 32'hC000_0000) return va - (va & 32'hE000_0000);
      return va;
   endfunction

   function automatic logic [31:0] randAddr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 2))
         0:       return 32'h8000_0000 | (r & 32'h1FFF_FFFC);
         1:       return 32'hA000_0000 | (r & 32'h1FFF_FFFC);
         default: return r & 32'h7FFF_FFFC;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mIDone = 1'b0; mDDone = 1'b0; mBusy = 1'b0; mOwnerD = 1'b0;
      mAccepted = 1'b0; mAborted = 1'b0; mWr = 1'b0;
      mInstRdata = 32'd0; mDataRdata = 32'd0; mAddr = 32'd0; mWdata = 32'd0; mStrb = 4'd0;
      reqAge = 0; dataAge = 0;
   endtask

   task automatic startTxn(input logic isData);
      mBusy = 1'b1; mOwnerD = isData; mAccepted = 1'b0; mAborted = 1'b0;
      reqAge = 0; dataAge = 0;
      aDly = fixedDly ? aDlyFix : int'($urandom_range(0, 2));
      dDly = fixedDly ? dDlyFix : int'($urandom_range(0, 2));
      if (isData) begin
         mAddr = phys(data_addr); mWr = |data_wen; mStrb = data_wen; mWdata = data_wdata;
      end else begin
         mAddr = phys(inst_addr); mWr = 1'b0; mStrb = 4'd0; mWdata = 32'd0;
      end
   endtask

   // one clock cycle: called at a falling edge with inputs already driven
   task automatic runCycle();
      logic iPend, dPend, expI, expD, expReq, ownerReq;
      if (!rst) modelReset();
      iPend  = inst_req & ~mIDone;
      dPend  = data_req & ~mDDone;
      expI   = iPend | (mBusy & ~mOwnerD);
      expD   = dPend | (mBusy & mOwnerD);
      expReq = mBusy & ~mAccepted;
      if (autoStall) longest_stall = expI | expD | (randExtra && ($urandom_range(0, 7) == 0));
      bus_addr_ok = expReq && (reqAge >= aDly);
      bus_data_ok = forceDataOk || (mBusy && mAccepted && (dataAge >= dDly));
      bus_rdata   = useRdataFix ? rdataFix : 32'($urandom);
      #1;
      chk("i_stall", {31'd0, i_stall}, {31'd0, expI});
      chk("d_stall", {31'd0, d_stall}, {31'd0, expD});
      chk("bus_req", {31'd0, bus_req}, {31'd0, expReq});
      chk("inst_rdata", inst_rdata, mInstRdata);
      chk("data_rdata", data_rdata, mDataRdata);
      if (expReq) begin
         chk("bus_addr", bus_addr, mAddr);
         chk("bus_wr", {31'd0, bus_wr}, {31'd0, mWr});
         chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, mStrb});
         chk("bus_wdata", bus_wdata, mWdata);
         chk("bus_size", {30'd0, bus_size}, 32'd2);
      end
      obsIStall = i_stall; obsDStall = d_stall; obsBusReq = bus_req;
      if (bus_req && bus_addr_ok) begin
         acceptAddr.push_back(bus_addr);
         acceptWr.push_back(bus_wr);
         acceptStrb.push_back(bus_wstrb);
      end
      if (rst) begin
         ownerReq = mOwnerD ? data_req : inst_req;
         if (!longest_stall) begin
            mIDone = 1'b0; mDDone = 1'b0;
         end
         if (mBusy && !mAccepted) begin
            if (!ownerReq) mAborted = 1'b1;
            if (bus_addr_ok) begin
               mAccepted = 1'b1; dataAge = 0;
            end else begin
               reqAge++;
            end
         end else if (mBusy) begin
            if (!ownerReq) mAborted = 1'b1;
            if (bus_data_ok) begin
               if (!mAborted && mOwnerD) begin
                  mDDone = 1'b1;
                  if (!mWr) mDataRdata = bus_rdata;
               end else if (!mAborted) begin
                  mIDone = 1'b1;
                  mInstRdata = bus_rdata;
               end
               mBusy = 1'b0;
            end else begin
               dataAge++;
            end
         end else if (dPend) begin
            startTxn(1'b1);
         end else if (iPend) begin
            startTxn(1'b0);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int stallCnt, iCnt, dCnt, dFall, iFall;
      modelReset();
      autoStall = 1'b1; randExtra = 1'b0; fixedDly = 1'b1; forceDataOk = 1'b0;
      useRdataFix = 1'b1; aDlyFix = 1; dDlyFix = 0; rdataFix = 32'd0;
      aDly = 0; dDly = 0;
      repeat (2) @(negedge clk);
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_bus_wr", {31'd0, bus_wr}, 32'd0);
      chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_inst_rdata", inst_rdata, 32'd0);
      chk("rst_data_rdata", data_rdata, 32'd0);
      chk("rst_i_stall_idle", {31'd0, i_stall}, 32'd0);
      inst_req = 1'b1;
      #1;
      chk("rst_i_stall_req", {31'd0, i_stall}, 32'd1);
      inst_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      runCycle();

      // lone fetch from the boot vector
      inst_addr = 32'hBFC0_0000; inst_req = 1'b1; rdataFix = 32'h2402_0001;
      acceptAddr.delete(); stallCnt = 0;
      for (int k = 0; k < 20; k++) begin
         runCycle();
         if (!obsIStall) break;
         stallCnt++;
      end
      chk("lone_stall_cycles", 32'(stallCnt), 32'd4);
      chk("lone_inst_rdata", inst_rdata, 32'h2402_0001);
      chk("lone_bus_addr", acceptAddr[0], 32'h1FC0_0000);
      inst_req = 1'b0;
      runCycle();

      // fetch and load together: load goes first
      inst_req = 1'b1; data_req = 1'b1; data_wen = 4'd0; data_addr = 32'h8000_1000;
      rdataFix = 32'h0BAD_F00D; acceptAddr.delete();
      iCnt = 0; dFall = -1; iFall = -1;
      for (int k = 0; k < 40; k++) begin
         runCycle();
         if (!obsDStall && dFall < 0) dFall = k;
         if (obsIStall) iCnt++;
         if (!obsIStall && !obsDStall) begin
            iFall = k;
            break;
         end
      end
      chk("dual_first_addr", acceptAddr[0], 32'h0000_1000);
      chk("dual_second_addr", acceptAddr[1], 32'h1FC0_0000);
      chk("dual_d_before_i", {31'd0, (dFall >= 0) && (dFall < iFall)}, 32'd1);
      chk("dual_i_stall_cycles", 32'(iCnt), 32'd8);
      chk("dual_data_rdata", data_rdata, 32'h0BAD_F00D);
      inst_req = 1'b0; data_req = 1'b0;
      runCycle();

      // partial-word store
      data_req = 1'b1; data_wen = 4'b0011; data_wdata = 32'h0000_BEEF; data_addr = 32'h0000_2000;
      rdataFix = 32'hDEAD_DEAD; acceptAddr.delete(); acceptWr.delete(); acceptStrb.delete(); dCnt = 0;
      for (int k = 0; k < 20; k++) begin
         runCycle();
         if (!obsDStall) break;
         dCnt++;
      end
      chk("store_bus_wr", {31'd0, acceptWr[0]}, 32'd1);
      chk("store_wstrb", {28'd0, acceptStrb[0]}, 32'h3);
      chk("store_data_rdata", data_rdata, 32'h0BAD_F00D);
      chk("store_d_stall_cycles", 32'(dCnt), 32'd4);
      data_req = 1'b0; data_wen = 4'd0;
      runCycle();

      // completed fetch held while the pipeline stays frozen
      autoStall = 1'b0; longest_stall = 1'b1;
      inst_addr = 32'hBFC0_0004; inst_req = 1'b1; rdataFix = 32'h3C1D_BFC0;
      for (int k = 0; k < 20; k++) begin
         runCycle();
         if (!obsIStall) break;
      end
      for (int k = 0; k < 3; k++) begin
         runCycle();
         chk("hold_i_stall", {31'd0, obsIStall}, 32'd0);
         chk("hold_no_reissue", {31'd0, obsBusReq}, 32'd0);
         chk("hold_inst_rdata", inst_rdata, 32'h3C1D_BFC0);
      end
      longest_stall = 1'b0;
      runCycle();
      chk("advance_i_stall", {31'd0, obsIStall}, 32'd0);
      longest_stall = 1'b1;
      runCycle();
      chk("cleared_i_stall", {31'd0, obsIStall}, 32'd1);
      inst_req = 1'b0; autoStall = 1'b1;
      repeat (8) runCycle();

      // load withdrawn while waiting for address accept
      aDlyFix = 2; rdataFix = 32'h1357_9BDF;
      data_req = 1'b1; data_wen = 4'd0; data_addr = 32'h0000_3000; acceptAddr.delete();
      runCycle();
      data_req = 1'b0;
      repeat (8) runCycle();
      chk("flush_accepted", 32'(acceptAddr.size()), 32'd1);
      chk("flush_data_rdata", data_rdata, 32'h0BAD_F00D);
      chk("flush_d_stall", {31'd0, obsDStall}, 32'd0);
      data_req = 1'b1;
      for (int k = 0; k < 20; k++) begin
         runCycle();
         if (!obsDStall) break;
      end
      chk("flush_reissued", 32'(acceptAddr.size()), 32'd2);
      chk("flush_reissue_rdata", data_rdata, 32'h1357_9BDF);
      data_req = 1'b0;
      runCycle();

      // reset during a fetch data phase
      aDlyFix = 0; dDlyFix = 2; rdataFix = 32'h2408_0008;
      inst_addr = 32'hBFC0_0008; inst_req = 1'b1;
      repeat (3) runCycle();
      chk("pre_reset_in_data_phase", {31'd0, mBusy & mAccepted & ~mOwnerD}, 32'd1);
      rst = 1'b0; forceDataOk = 1'b1;
      runCycle();
      chk("reset_inst_rdata", inst_rdata, 32'd0);
      chk("reset_bus_addr", bus_addr, 32'd0);
      forceDataOk = 1'b0;
      runCycle();
      rst = 1'b1; acceptAddr.delete();
      for (int k = 0; k < 20; k++) begin
         runCycle();
         if (!obsIStall) break;
      end
      chk("post_reset_fetch_addr", acceptAddr[0], 32'h1FC0_0008);
      chk("post_reset_inst_rdata", inst_rdata, 32'h2408_0008);
      inst_req = 1'b0;
      runCycle();

      // randomized traffic
      fixedDly = 1'b0; useRdataFix = 1'b0; randExtra = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (!longest_stall) begin
            inst_req   = ($urandom_range(0, 9) != 0);
            inst_addr  = randAddr();
            data_req   = ($urandom_range(0, 9) < 4);
            data_wen   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            data_addr  = randAddr();
            data_wdata = $urandom;
         end else begin
            if ($urandom_range(0, 31) == 0) inst_req = 1'b0;
            if ($urandom_range(0, 31) == 0) data_req = 1'b0;
         end
         runCycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
